// File: rtl/medidor_pkg.sv
// medidor_pkg: FSM states, counter limits and seven-segment/anode tables shared by medidor_frec
package medidor_pkg;
  typedef enum logic [1:0] {MEASURE, CONVERT, UPDATE} state_e;
  localparam int GW = 26;
  localparam logic [13:0] CNT_MAX = 14'd9999;
  localparam logic [3:0] CONV_STEPS = 4'd14;
  localparam logic [9:0][7:0] SEG_TAB = {8'h09, 8'h01, 8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03};
  localparam logic [3:0][7:0] ANODES = {8'hEF, 8'hDF, 8'hBF, 8'h7F};
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    return d > 4'd9 ? 8'h00 : SEG_TAB[d];
  endfunction
endpackage

// File: rtl/bin_a_bcd.sv
// bin_a_bcd: 14-cycle shift-add-3 binary to 4-digit BCD converter; done marks the final step
module bin_a_bcd
  import medidor_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [13:0] bin,
  output logic        done,
  output logic [15:0] bcd
);
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d, adj;
  logic [3:0]  step_q, step_d;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] > 4'd4 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    bin_d  = start ? bin : step_q != 4'd0 ? {bin_q[12:0], 1'b0} : bin_q;
    bcd_d  = start ? '0 : step_q != 4'd0 ? (adj << 1) | {15'd0, bin_q[13]} : bcd_q;
    step_d = start ? CONV_STEPS : step_q != 4'd0 ? step_q - 4'd1 : step_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      step_q <= '0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      step_q <= step_d;
    end
  end
  assign done = step_q == 4'd1;
  assign bcd  = bcd_q;
endmodule

// File: rtl/medidor_frec.sv
// medidor_frec: counts SENAL rising edges per GATE_CYCLES window and reports them in BCD.
// Define MEDIDOR_DISP_EN to add the multiplexed 4-digit seven-segment driver on DISPLAY.
module medidor_frec
  import medidor_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int SCAN_CYCLES = 166_666
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SENAL,
  output logic [15:0] BCD,
  output logic        VALID,
  output logic        OVF,
  output logic [15:0] DISPLAY
);
  if (GATE_CYCLES < 32 || GATE_CYCLES > 2**26 - 1) begin : g_bad_gate
    $error("GATE_CYCLES out of range");
  end
  if (SCAN_CYCLES < 1) begin : g_bad_scan
    $error("SCAN_CYCLES must be positive");
  end
  state_e        state_q, state_d;
  logic [2:0]    s_q, s_d;
  logic [GW-1:0] gate_q, gate_d;
  logic [13:0]   cnt_q, cnt_d, cnt_fin;
  logic          ovf_q, ovf_d, ovf_fin, snap_ovf_q, snap_ovf_d;
  logic [15:0]   bcd_q, bcd_d, conv_bcd;
  logic          ovf_o_q, ovf_o_d, valid_q, valid_d;
  logic          rise, term, sat, start, upd, conv_done;
  // the closing window's final edge lands in cnt_fin, so the snapshot and the clear share one cycle
  always_comb begin
    s_d        = {s_q[1:0], SENAL};
    rise       = s_q[1] & ~s_q[2];
    term       = gate_q == GW'(GATE_CYCLES - 1);
    gate_d     = term ? '0 : gate_q + 1'b1;
    sat        = cnt_q == CNT_MAX;
    cnt_fin    = cnt_q + {13'd0, rise & ~sat};
    ovf_fin    = ovf_q | (rise & sat);
    cnt_d      = term ? '0 : cnt_fin;
    ovf_d      = term ? 1'b0 : ovf_fin;
    snap_ovf_d = term ? ovf_fin : snap_ovf_q;
    start      = state_q == MEASURE && term;
    upd        = state_q == UPDATE;
    state_d    = state_q == MEASURE ? (term ? CONVERT : MEASURE) :
                 state_q == CONVERT ? (conv_done ? UPDATE : CONVERT) : MEASURE;
    valid_d    = upd;
    bcd_d      = upd ? (snap_ovf_q ? 16'h9999 : conv_bcd) : bcd_q;
    ovf_o_d    = upd ? snap_ovf_q : ovf_o_q;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= MEASURE;
    else state_q <= state_d;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_q        <= '0;
      gate_q     <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      snap_ovf_q <= 1'b0;
      bcd_q      <= '0;
      ovf_o_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      s_q        <= s_d;
      gate_q     <= gate_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      snap_ovf_q <= snap_ovf_d;
      bcd_q      <= bcd_d;
      ovf_o_q    <= ovf_o_d;
      valid_q    <= valid_d;
    end
  end
  bin_a_bcd u_conv (
    .clk  (CLK),
    .rst_n(RST_N),
    .start(start),
    .bin  (cnt_fin),
    .done (conv_done),
    .bcd  (conv_bcd)
  );
  assign BCD   = bcd_q;
  assign VALID = valid_q;
  assign OVF   = ovf_o_q;
`ifdef MEDIDOR_DISP_EN
  localparam int SW = $clog2(SCAN_CYCLES + 1);
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   disp_q, disp_d;
  // digit 0 is the thousands nibble, hence the inverted index
  always_comb begin
    scan_d = scan_q == SW'(SCAN_CYCLES - 1) ? '0 : scan_q + 1'b1;
    dig_d  = scan_q == SW'(SCAN_CYCLES - 1) ? dig_q + 2'd1 : dig_q;
    disp_d = {seg_of(bcd_q[{~dig_q, 2'b00} +: 4]), ANODES[dig_q]};
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scan_q <= '0;
      dig_q  <= '0;
      disp_q <= 16'hFFFF;
    end else begin
      scan_q <= scan_d;
      dig_q  <= dig_d;
      disp_q <= disp_d;
    end
  end
  assign DISPLAY = disp_q;
`else
  assign DISPLAY = 16'hFFFF;
`endif
endmodule

// File: tb/tb_medidor_frec.sv
// tb_medidor_frec: window-count reference model against three medidor_frec instances
module tb_medidor_frec;
  localparam int GA = 1000, GB = 40000, GC = 3000, MAXN = 3200;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n_a = 1'b0, rst_n_b = 1'b0, senal_a = 1'b0, senal_b = 1'b0, senal_c = 1'b0;
  logic [15:0] bcd_a, bcd_b, bcd_c, disp_a, disp_b, disp_c;
  logic valid_a, valid_b, valid_c, ovf_a, ovf_b, ovf_c;
  int checks = 0, errors = 0;
  bit stim_a [MAXN];
  bit stim_c [MAXN];
  logic [15:0] disp_log [MAXN];
  int vcyc[$], ccyc[$], ecyc[$];
  logic [15:0] vbcd[$], cbcd[$], ebcd[$];
  logic vovf[$], eovf[$];
  int hold_bad, disp_bad;

  medidor_frec #(.GATE_CYCLES(GA), .SCAN_CYCLES(4)) u_a (.CLK(clk), .RST_N(rst_n_a), .SENAL(senal_a),
    .BCD(bcd_a), .VALID(valid_a), .OVF(ovf_a), .DISPLAY(disp_a));
  medidor_frec #(.GATE_CYCLES(GB), .SCAN_CYCLES(4)) u_b (.CLK(clk), .RST_N(rst_n_b), .SENAL(senal_b),
    .BCD(bcd_b), .VALID(valid_b), .OVF(ovf_b), .DISPLAY(disp_b));
  medidor_frec #(.GATE_CYCLES(GC), .SCAN_CYCLES(4)) u_c (.CLK(clk), .RST_N(rst_n_a), .SENAL(senal_c),
    .BCD(bcd_c), .VALID(valid_c), .OVF(ovf_c), .DISPLAY(disp_c));

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // a rise driven in cycle c is seen two synchroniser stages later, in window (c+2)/G;
  // window w reports 16 cycles after its last cycle, saturating at 9999
  task automatic model_a(input int n);
    int cnt [];
    cnt = new[n / GA + 2];
    ecyc.delete(); ebcd.delete(); eovf.delete();
    for (int c = 0; c < n; c++)
      if (stim_a[c] && (c == 0 || !stim_a[c-1])) cnt[(c + 2) / GA]++;
    for (int w = 0; w < n / GA + 1; w++)
      if (w * GA + GA + 15 < n) begin
        ecyc.push_back(w * GA + GA + 15);
        ebcd.push_back(to_bcd(cnt[w] > 9999 ? 9999 : cnt[w]));
        eovf.push_back(cnt[w] > 9999);
      end
  endtask

  task automatic clear_stim;
    for (int c = 0; c < MAXN; c++) begin
      stim_a[c] = 1'b0;
      stim_c[c] = 1'b0;
    end
  endtask

  task automatic play(input int n);
    logic [15:0] pb;
    logic po;
    vcyc.delete(); vbcd.delete(); vovf.delete(); ccyc.delete(); cbcd.delete();
    hold_bad = 0;
    disp_bad = 0;
    @(negedge clk);
    rst_n_a = 1'b0; senal_a = 1'b0; senal_c = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_a = 1'b1;
    pb = 16'h0000;
    po = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      senal_a = stim_a[c];
      senal_c = stim_c[c];
      if (valid_a) begin
        vcyc.push_back(c); vbcd.push_back(bcd_a); vovf.push_back(ovf_a);
      end else if (bcd_a !== pb || ovf_a !== po) hold_bad++;
      pb = bcd_a;
      po = ovf_a;
      if (valid_c) begin
        ccyc.push_back(c); cbcd.push_back(bcd_c);
      end
      disp_log[c] = disp_c;
      if (disp_a !== 16'hFFFF) disp_bad++;
    end
  endtask

  task automatic test_reset;
    clear_stim();
    for (int c = 0; c < 40; c++) stim_a[c] = c[0];
    play(40);
    rst_n_a = 1'b0;
    #1;
    checks++; if (bcd_a !== 16'h0000) begin errors++; $display("FAIL reset_bcd got %h exp 0000", bcd_a); end
    checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_a); end
    checks++; if (ovf_a !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf_a); end
    checks++; if (disp_a !== 16'hFFFF) begin errors++; $display("FAIL reset_display got %h exp FFFF", disp_a); end
  endtask

  task automatic test_period20;
    clear_stim();
    for (int c = 0; c < MAXN; c++) stim_a[c] = (c % 20) < 10;
    play(2020);
    model_a(2020);
    checks++; if (vcyc.size() != ecyc.size()) begin errors++; $display("FAIL p20_pulses got %0d exp %0d", vcyc.size(), ecyc.size()); end
    foreach (ecyc[i]) if (i < vcyc.size()) begin
      checks++;
      if (vcyc[i] != ecyc[i] || vbcd[i] !== ebcd[i] || vovf[i] !== eovf[i] || vbcd[i] !== 16'h0050) begin
        errors++;
        $display("FAIL p20_win%0d got cyc %0d bcd %h ovf %b exp cyc %0d bcd %h ovf %b", i, vcyc[i], vbcd[i], vovf[i], ecyc[i], ebcd[i], eovf[i]);
      end
    end
    checks++; if (hold_bad != 0) begin errors++; $display("FAIL p20_hold got %0d changes exp 0", hold_bad); end
  endtask

  task automatic test_const_high;
    clear_stim();
    for (int c = 0; c < MAXN; c++) stim_a[c] = 1'b1;
    play(3020);
    model_a(3020);
    checks++; if (vcyc.size() != 3) begin errors++; $display("FAIL high_pulses got %0d exp 3", vcyc.size()); end
    foreach (ecyc[i]) if (i < vcyc.size()) begin
      checks++;
      if (vcyc[i] != ecyc[i] || vbcd[i] !== ebcd[i] || vovf[i] !== eovf[i] || (i > 0 && vbcd[i] !== 16'h0000)) begin
        errors++;
        $display("FAIL high_win%0d got cyc %0d bcd %h ovf %b exp cyc %0d bcd %h ovf %b", i, vcyc[i], vbcd[i], vovf[i], ecyc[i], ebcd[i], eovf[i]);
      end
    end
    for (int i = 1; i < vcyc.size(); i++) begin
      checks++; if (vcyc[i] - vcyc[i-1] != GA) begin errors++; $display("FAIL high_spacing got %0d exp %0d", vcyc[i] - vcyc[i-1], GA); end
    end
  endtask

  task automatic test_terminal_edge;
    clear_stim();
    for (int c = 2; c < MAXN; c++) stim_a[c] = ((c + 3) % 10) < 5;
    play(3020);
    model_a(3020);
    checks++; if (vcyc.size() != ecyc.size()) begin errors++; $display("FAIL term_pulses got %0d exp %0d", vcyc.size(), ecyc.size()); end
    foreach (ecyc[i]) if (i < vcyc.size()) begin
      checks++;
      if (vcyc[i] != ecyc[i] || vbcd[i] !== ebcd[i] || vbcd[i] !== 16'h0100 || vovf[i] !== 1'b0) begin
        errors++;
        $display("FAIL term_win%0d got cyc %0d bcd %h ovf %b exp cyc %0d bcd 0100 ovf 0", i, vcyc[i], vbcd[i], vovf[i], ecyc[i]);
      end
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 3; it++) begin
      int p, h;
      clear_stim();
      p = $urandom_range(2, 40);
      h = $urandom_range(1, p - 1);
      for (int c = 0; c < MAXN; c++)
        stim_a[c] = it == 0 ? ($urandom_range(0, 3) == 0) : it == 1 ? ($urandom_range(0, 1) == 1) : ((c % p) < h);
      play(2020);
      model_a(2020);
      checks++; if (vcyc.size() != ecyc.size()) begin errors++; $display("FAIL rnd%0d_pulses got %0d exp %0d", it, vcyc.size(), ecyc.size()); end
      foreach (ecyc[i]) if (i < vcyc.size()) begin
        checks++;
        if (vcyc[i] != ecyc[i] || vbcd[i] !== ebcd[i] || vovf[i] !== eovf[i]) begin
          errors++;
          $display("FAIL rnd%0d_win%0d got cyc %0d bcd %h ovf %b exp cyc %0d bcd %h ovf %b", it, i, vcyc[i], vbcd[i], vovf[i], ecyc[i], ebcd[i], eovf[i]);
        end
      end
      checks++; if (hold_bad != 0) begin errors++; $display("FAIL rnd%0d_hold got %0d changes exp 0", it, hold_bad); end
    end
  endtask

  task automatic test_reset_convert;
    clear_stim();
    for (int c = 0; c < MAXN; c++) stim_a[c] = (c % 20) < 10;
    play(2004);
    checks++; if (bcd_a !== 16'h0050) begin errors++; $display("FAIL rc_before got %h exp 0050", bcd_a); end
    rst_n_a = 1'b0;
    #1;
    checks++; if (bcd_a !== 16'h0000 || valid_a !== 1'b0 || ovf_a !== 1'b0) begin
      errors++; $display("FAIL rc_async got bcd %h valid %b ovf %b exp 0000 0 0", bcd_a, valid_a, ovf_a);
    end
    play(1100);
    model_a(1100);
    checks++; if (vcyc.size() != 1 || ecyc.size() != 1) begin errors++; $display("FAIL rc_pulses got %0d exp 1", vcyc.size()); end
    if (vcyc.size() > 0) begin
      checks++;
      if (vcyc[0] != 1015 || vcyc[0] != ecyc[0] || vbcd[0] !== 16'h0050 || vbcd[0] !== ebcd[0]) begin
        errors++; $display("FAIL rc_first got cyc %0d bcd %h exp cyc 1015 bcd 0050", vcyc[0], vbcd[0]);
      end
    end
  endtask

  task automatic test_display;
    int st;
    clear_stim();
    for (int c = 0; c < 2468; c += 2) stim_c[c] = 1'b1;
    play(3060);
    checks++; if (ccyc.size() != 1) begin errors++; $display("FAIL disp_pulses got %0d exp 1", ccyc.size()); end
    if (ccyc.size() > 0) begin
      checks++; if (ccyc[0] != GC + 15 || cbcd[0] !== 16'h1234) begin errors++; $display("FAIL disp_value got cyc %0d bcd %h exp cyc %0d bcd 1234", ccyc[0], cbcd[0], GC + 15); end
    end
`ifdef MEDIDOR_DISP_EN
    st = -1;
    for (int c = 3018; c < 3040; c++)
      if (st < 0 && disp_log[c] === 16'h9F7F && disp_log[c-1] !== 16'h9F7F) st = c;
    checks++; if (st < 0) begin errors++; $display("FAIL disp_start got none exp 9F7F run"); end
    else begin
      checks++; if (disp_log[st+3] !== 16'h9F7F) begin errors++; $display("FAIL disp_hold got %h exp 9F7F", disp_log[st+3]); end
      checks++; if (disp_log[st+4] !== 16'h25BF) begin errors++; $display("FAIL disp_d1 got %h exp 25BF", disp_log[st+4]); end
      checks++; if (disp_log[st+8] !== 16'h0DDF) begin errors++; $display("FAIL disp_d2 got %h exp 0DDF", disp_log[st+8]); end
      checks++; if (disp_log[st+12] !== 16'h99EF) begin errors++; $display("FAIL disp_d3 got %h exp 99EF", disp_log[st+12]); end
      checks++; if (disp_log[st+16] !== 16'h9F7F) begin errors++; $display("FAIL disp_wrap got %h exp 9F7F", disp_log[st+16]); end
    end
`else
    st = 0;
    for (int c = 0; c < 3060; c++) if (disp_log[c] !== 16'hFFFF) st++;
    checks++; if (st != 0 || disp_bad != 0) begin errors++; $display("FAIL disp_tied got %0d non-FFFF cycles exp 0", st + disp_bad); end
`endif
  endtask

  task automatic test_overflow;
    int pc[$];
    logic [15:0] pb[$];
    logic po[$];
    rst_n_b = 1'b0;
    senal_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n_b = 1'b1;
    for (int c = 0; c < 2 * GB + 20; c++) begin
      if (c > 0) @(negedge clk);
      senal_b = c < 39500 ? (c % 2 == 0) : ((c % 8) < 4);
      if (valid_b) begin
        pc.push_back(c); pb.push_back(bcd_b); po.push_back(ovf_b);
      end
    end
    checks++; if (pc.size() != 2) begin errors++; $display("FAIL ovf_pulses got %0d exp 2", pc.size()); end
    if (pc.size() > 0) begin
      checks++; if (pc[0] != GB + 15 || pb[0] !== 16'h9999 || po[0] !== 1'b1) begin
        errors++; $display("FAIL ovf_win0 got cyc %0d bcd %h ovf %b exp cyc %0d bcd 9999 ovf 1", pc[0], pb[0], po[0], GB + 15);
      end
    end
    if (pc.size() > 1) begin
      checks++; if (pc[1] != 2 * GB + 15 || pb[1] !== 16'h5000 || po[1] !== 1'b0) begin
        errors++; $display("FAIL ovf_win1 got cyc %0d bcd %h ovf %b exp cyc %0d bcd 5000 ovf 0", pc[1], pb[1], po[1], 2 * GB + 15);
      end
    end
  endtask

  initial begin
    fork
      test_overflow();
      begin
        test_reset();
        test_period20();
        test_const_high();
        test_terminal_edge();
        test_random();
        test_reset_convert();
        test_display();
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/medidor_frec.md
MEDIDOR_FREC -- requirements
Module: medidor_frec

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50_000_000, meaning measurement window length in CLK cycles (1 s at 50 MHz); legal range 32 .. 2^26-1.
REQ-002 SHALL have parameter SCAN_CYCLES, default 166_666, meaning CLK cycles each display digit is held (only used with MEDIDOR_DISP_EN).
REQ-003 SHALL have port CLK  input  1  system clock, all logic rising-edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port SENAL  input  1  asynchronous signal under measurement (the variable-frequency generator output SALIDA).
REQ-006 SHALL have port BCD  output  16  last result, {MILL,CENT,DECE,UNID}, each digit 0-9.
REQ-007 SHALL have port VALID  output  1  one-cycle pulse when BCD/OVF update.
REQ-008 SHALL have port OVF  output  1  last window had more than 9999 rising edges.
REQ-009 SHALL have port DISPLAY  output  16  {segments[7:0], anodes[7:0]}, active-low.

Function
REQ-010 SHALL synchronise SENAL through two flops, then detect a rising edge when the synchronised value is 1 and its one-cycle-delayed copy is 0.
REQ-011 SHALL run a free gate counter 0..GATE_CYCLES-1, wrapping to 0; the cycle at GATE_CYCLES-1 is the terminal cycle.
REQ-012 SHALL count detected edges in a 14-bit counter saturating at 9999; any edge beyond 9999 sets a window overflow flag.
REQ-013 SHALL include an edge detected in the terminal cycle in the closing window; in that cycle the counter and flag SHALL be snapshotted and cleared to 0, with no edge lost or double-counted.
REQ-014 SHALL use FSM states MEASURE, CONVERT, UPDATE: MEASURE->CONVERT on terminal cycle; CONVERT runs exactly 14 cycles of shift-add-3 binary-to-BCD on the snapshot; CONVERT->UPDATE; UPDATE->MEASURE after 1 cycle.
REQ-015 SHALL, in UPDATE, register BCD and OVF and pulse VALID high for exactly one cycle; VALID is high 16 cycles after the terminal cycle.
REQ-016 SHALL keep edge counting and the gate counter running during CONVERT/UPDATE (windows contiguous).
REQ-017 SHALL present BCD=16'h9999 whenever OVF=1.
REQ-018 SHALL hold BCD/OVF stable between VALID pulses.

Reset
REQ-019 SHALL, on RST_N low, immediately set BCD=0, VALID=0, OVF=0, DISPLAY=16'hFFFF, all counters, synchronisers and snapshot to 0, FSM to MEASURE.
REQ-020 SHALL, on reset during CONVERT or UPDATE, abandon the conversion; the first VALID after release follows the first complete window.

Configuration
REQ-021 SHALL, with macro MEDIDOR_DISP_EN defined, include a 4-digit scan driver: a digit index 0..3 advances every SCAN_CYCLES, wrapping; digit 0 = MILL with anodes 8'b01111111, 1 = CENT/8'b10111111, 2 = DECE/8'b11011111, 3 = UNID/8'b11101111.
REQ-022 SHALL encode segments 0..9 as 03,9F,25,0D,99,49,41,1F,01,09 (hex); any other value drives 8'h00.
REQ-023 SHALL, without MEDIDOR_DISP_EN, tie DISPLAY to 16'hFFFF and omit scan logic.

Structure
REQ-024 SHALL place FSM state encoding, the segment table and the anode patterns in shared package medidor_pkg.
REQ-025 SHALL implement the sequential converter as sub-module bin_a_bcd (start, 14-bit in, done, 16-bit out).

Verification
REQ-026 SHALL verify GATE_CYCLES=1000, SENAL period 20 clk -> VALID 16 cycles after terminal cycle, BCD=16'h0050, OVF=0.
REQ-027 SHALL verify SENAL held constant 1 -> BCD=16'h0000 each window, VALID every 1000 cycles.
REQ-028 SHALL verify GATE_CYCLES=40000, SENAL toggling every cycle (20000 edges) -> BCD=16'h9999, OVF=1; then period 8 -> next full window BCD=16'h5000, OVF=0.
REQ-029 SHALL verify RST_N pulsed low during CONVERT -> outputs 0 immediately, no VALID until one full window after release.
REQ-030 SHALL verify an edge placed on the terminal cycle -> counted in the closing window only (period 10, GATE_CYCLES=1000, aligned -> 0100 every window).
REQ-031 SHALL verify, with MEDIDOR_DISP_EN, SCAN_CYCLES=4, BCD=16'h1234 -> DISPLAY cycles 16'h9F7F, 16'h25BF, 16'h0DDF, 16'h99EF.
